// File: rtl/vector_cache_pkg.sv
// Shared types and default sizing for the vector cache eviction data buffer.
package vector_cache_pkg;

    localparam int MSHR_ENTRY_IDX_WIDTH = 6;
    localparam int EVDB_ENTRY_NUM       = 8;
    localparam int EVDB_BEATS           = 4;
    localparam int EVDB_DATA_WIDTH      = 1024;
    localparam int EVDB_RD_LAT          = 2;
    localparam int EVDB_OBUF_DEPTH      = 4;
    localparam int EVDB_TXNID_WIDTH     = 12;
    localparam int EVDB_SB_WIDTH        = 8;
    localparam int EVDB_ADDR_WIDTH      = 48;
    localparam int EVDB_ENTRY_W         = $clog2(EVDB_ENTRY_NUM);
    localparam int EVDB_BEAT_W          = (EVDB_BEATS > 1) ? $clog2(EVDB_BEATS) : 1;

    typedef struct packed {
        logic [EVDB_ENTRY_W-1:0]         entry;
        logic [EVDB_BEAT_W-1:0]          beat;
        logic                            last;
        logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
        logic [EVDB_TXNID_WIDTH-1:0]     txnid;
        logic [EVDB_SB_WIDTH-1:0]        sideband;
        logic [EVDB_ADDR_WIDTH-1:0]      addr;
    } evdb_req_t;

    // Per-line attributes captured from the last beat of each line.
    typedef struct packed {
        logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
        logic [EVDB_TXNID_WIDTH-1:0]     txnid;
        logic [EVDB_SB_WIDTH-1:0]        sideband;
        logic [EVDB_ADDR_WIDTH-1:0]      addr;
    } evdb_meta_t;

    typedef struct packed {
        logic [EVDB_DATA_WIDTH-1:0]           data;
        logic [MSHR_ENTRY_IDX_WIDTH-1:0]      rob_entry_id;
        logic [EVDB_TXNID_WIDTH-1:0]          txnid;
        logic [EVDB_SB_WIDTH-1:0]             sideband;
        logic [EVDB_ADDR_WIDTH-1:0]           addr;
        logic [EVDB_ENTRY_W+EVDB_BEAT_W-1:0]  db_entry_id;
        logic                                 last;
    } evict_to_ds_pld_t;

endpackage

// File: rtl/evdb_sync_fifo.sv
// Synchronous FIFO with registered storage and a show-ahead head word.
module evdb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;

    // Explicit wrap so non power-of-two depths work.
    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= ptr_nxt(wptr);
            if (pop)  rptr <= ptr_nxt(rptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end

    assign head = mem[rptr];

endmodule

// File: rtl/toy_mem_model_bit.sv
// Single-port data array, one-cycle registered read; contents are never reset.
module toy_mem_model_bit #(
    parameter int DW = 64,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/evict_db_mb.sv
// Eviction data buffer: captures evicted lines beat by beat from RAM and
// drains each completed line downstream in order, recycling its entry.
module evict_db_mb
    import vector_cache_pkg::*;
#(
    parameter int ENTRY_NUM  = EVDB_ENTRY_NUM,
    parameter int BEATS      = EVDB_BEATS,
    parameter int DATA_WIDTH = EVDB_DATA_WIDTH,
    parameter int RD_LAT     = EVDB_RD_LAT,
    parameter int OBUF_DEPTH = EVDB_OBUF_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    output logic                            alloc_vld,
    output logic [$clog2(ENTRY_NUM)-1:0]    alloc_idx,
    input  logic                            alloc_rdy,
    input  logic                            evict_req_vld,
    input  evdb_req_t                       evict_req_pld,
    output logic                            evict_req_rdy,
    input  logic                            ram_to_evdb_data_vld,
    input  logic [DATA_WIDTH-1:0]           ram_to_evdb_data_in,
    output logic                            evict_clean,
    output logic [MSHR_ENTRY_IDX_WIDTH-1:0] evict_clean_idx,
    output logic                            evict_to_ds_vld,
    output evict_to_ds_pld_t                evict_to_ds_pld,
    input  logic                            evict_to_ds_rdy,
    output logic [$clog2(ENTRY_NUM):0]      occupancy,
    output logic                            err_nodata
);
    localparam int EW   = $clog2(ENTRY_NUM);
    localparam int BW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW   = EW + BW;
    localparam int STG  = RD_LAT - 1;
    localparam int OW   = DATA_WIDTH + AW;
    localparam int OCW  = $clog2(OBUF_DEPTH + 1);
    localparam int QCW  = $clog2(ENTRY_NUM + 1);
    localparam int OCCW = EW + 1;
    localparam int DBW  = EVDB_ENTRY_W + EVDB_BEAT_W;

    typedef enum logic [1:0] {IDLE, READ, WAIT_REL} drain_st_t;

    logic [STG:0]    vld_pipe;
    evdb_req_t       pld_pipe [STG:0];
    evdb_meta_t      meta [ENTRY_NUM];
    logic            wr_en;
    evdb_req_t       wr_pld;
    logic [EW-1:0]   wr_entry;
    logic [BW-1:0]   wr_beat;
    logic            line_done;

    assign wr_en     = vld_pipe[STG];
    assign wr_pld    = pld_pipe[STG];
    assign wr_entry  = EW'(wr_pld.entry);
    assign wr_beat   = BW'(wr_pld.beat);
    assign line_done = wr_en && wr_pld.last;

    // Write path: request stage 0 lines up with RAM data after RD_LAT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe        <= '0;
            evict_req_rdy   <= 1'b0;
            evict_clean     <= 1'b0;
            evict_clean_idx <= '0;
            err_nodata      <= 1'b0;
        end else begin
            evict_req_rdy <= 1'b1;
            vld_pipe[0]   <= evict_req_vld && evict_req_rdy;
            for (int i = 1; i <= STG; i++) vld_pipe[i] <= vld_pipe[i-1];
            evict_clean <= line_done;
            if (line_done) evict_clean_idx <= wr_pld.rob_entry_id;
            if (wr_en && !ram_to_evdb_data_vld) err_nodata <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        pld_pipe[0] <= evict_req_pld;
        for (int i = 1; i <= STG; i++) pld_pipe[i] <= pld_pipe[i-1];
        if (line_done) begin
            meta[wr_entry] <= '{rob_entry_id: wr_pld.rob_entry_id, txnid: wr_pld.txnid,
                                sideband: wr_pld.sideband, addr: wr_pld.addr};
        end
    end

    // Drain queue of completed lines.
    logic [QCW-1:0] dq_cnt;
    logic [EW-1:0]  dq_head;
    logic           dq_pop;

    evdb_sync_fifo #(.WIDTH(EW), .DEPTH(ENTRY_NUM)) u_drain_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (line_done),
        .push_data (wr_entry),
        .pop       (dq_pop),
        .head      (dq_head),
        .count     (dq_cnt)
    );

    // Drain FSM and data array port arbitration (writes win).
    drain_st_t       st, st_nx;
    logic [EW-1:0]   cur_entry;
    logic [BW-1:0]   beat_q;
    logic            rd_issue;
    logic            rd_pending;
    logic [AW-1:0]   rd_tag;
    logic            rel;
    logic [AW-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [OW-1:0]   ob_head;
    logic [OCW-1:0]  ob_cnt;
    logic [EW-1:0]   ob_entry;
    logic [BW-1:0]   ob_beat;
    logic            ob_last;
    logic            ds_fire;

    assign mem_addr = wr_en ? {wr_entry, wr_beat} : {cur_entry, beat_q};

    toy_mem_model_bit #(.DW(DATA_WIDTH), .AW(AW)) u_data_mem (
        .clk   (clk),
        .en    (wr_en || rd_issue),
        .we    (wr_en),
        .addr  (mem_addr),
        .wdata (ram_to_evdb_data_in),
        .rdata (mem_rdata)
    );

    always_comb begin
        st_nx    = st;
        dq_pop   = 1'b0;
        rd_issue = 1'b0;
        rel      = 1'b0;
        case (st)
            IDLE: if (dq_cnt != '0) begin
                dq_pop = 1'b1;
                st_nx  = READ;
            end
            READ: if (!wr_en && ((int'(rd_pending) + int'(ob_cnt)) < OBUF_DEPTH)) begin
                rd_issue = 1'b1;
                if (beat_q == BW'(BEATS-1)) st_nx = WAIT_REL;
            end
            WAIT_REL: if (ds_fire && ob_last) begin
                rel   = 1'b1;
                st_nx = IDLE;
            end
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            cur_entry  <= '0;
            beat_q     <= '0;
            rd_pending <= 1'b0;
            rd_tag     <= '0;
        end else begin
            st         <= st_nx;
            rd_pending <= rd_issue;
            if (dq_pop) begin
                cur_entry <= dq_head;
                beat_q    <= '0;
            end
            if (rd_issue) begin
                beat_q <= beat_q + 1'b1;
                rd_tag <= {cur_entry, beat_q};
            end
        end
    end

    // Output buffer; credit check above guarantees it never overflows.
    evdb_sync_fifo #(.WIDTH(OW), .DEPTH(OBUF_DEPTH)) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pending),
        .push_data ({mem_rdata, rd_tag}),
        .pop       (ds_fire),
        .head      (ob_head),
        .count     (ob_cnt)
    );

    assign ob_entry        = ob_head[AW-1:BW];
    assign ob_beat         = ob_head[BW-1:0];
    assign ob_last         = (ob_beat == BW'(BEATS-1));
    assign evict_to_ds_vld = (ob_cnt != '0);
    assign ds_fire         = evict_to_ds_vld && evict_to_ds_rdy;

    always_comb begin
        evict_to_ds_pld              = '0;
        evict_to_ds_pld.data         = EVDB_DATA_WIDTH'(ob_head[OW-1:AW]);
        evict_to_ds_pld.rob_entry_id = meta[ob_entry].rob_entry_id;
        evict_to_ds_pld.txnid        = meta[ob_entry].txnid;
        evict_to_ds_pld.sideband     = meta[ob_entry].sideband;
        evict_to_ds_pld.addr         = meta[ob_entry].addr;
        evict_to_ds_pld.db_entry_id  = DBW'({ob_entry, ob_beat});
        evict_to_ds_pld.last         = ob_last;
    end

    // Free bitmap; allocation and release in one cycle both land.
    logic [ENTRY_NUM-1:0] free_q, free_nx;
    logic [EW-1:0]        lo_idx;

    always_comb begin
        free_nx = free_q;
        if (alloc_vld && alloc_rdy) free_nx[alloc_idx] = 1'b0;
        if (rel) free_nx[cur_entry] = 1'b1;
        lo_idx = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (free_nx[i]) lo_idx = EW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_q    <= '1;
            alloc_vld <= 1'b0;
            alloc_idx <= '0;
        end else begin
            free_q    <= free_nx;
            alloc_vld <= |free_nx;
            alloc_idx <= lo_idx;
        end
    end

    assign occupancy = OCCW'(ENTRY_NUM - $countones(free_q));

endmodule
